// File: rtl/floppy_timer_pkg.sv
// Shared constants and types for the floppy tick-timer controller.
package floppy_timer_pkg;

  // Number of independent timer channels and the width of each counter.
  localparam int NCH = 4;
  localparam int CW  = 8;

  // Prescaler counter width; the divider must fit in it.
  localparam int PSW = 18;

  // Register map.
  localparam logic [2:0] ADDR_CH0  = 3'd0;
  localparam logic [2:0] ADDR_CH1  = 3'd1;
  localparam logic [2:0] ADDR_CH2  = 3'd2;
  localparam logic [2:0] ADDR_CH3  = 3'd3;
  localparam logic [2:0] ADDR_CTRL = 3'd4;
  localparam logic [2:0] ADDR_STAT = 3'd5;

  // Clocks per tick for a given master clock and tick rate.
  function automatic int calc_div(input int mclk_hz, input int tick_hz);
    return mclk_hz / tick_hz;
  endfunction

  // Default operating point: 24 MHz master clock, 100 Hz tick.
  localparam int MCLKFREQ_DEF = 24000000;
  localparam int TICKHZ_DEF   = 100;
  localparam int DIV          = calc_div(MCLKFREQ_DEF, TICKHZ_DEF);

  // CTRL register layout: IRQ enables in the high nibble, auto-reload in the low.
  typedef struct packed {
    logic [NCH-1:0] ie;
    logic [NCH-1:0] ar;
  } ctrl_t;

endpackage

// File: rtl/floppy_timer_chan.sv
// One timer channel: 8-bit down-counter with reload register and auto-reload.
module floppy_timer_chan
  import floppy_timer_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          load,
  input  logic [CW-1:0] ld_val,
  input  logic          ar,
  output logic [CW-1:0] count,
  output logic          expire_pulse
);

  logic [CW-1:0] reload;

  // A load in a tick cycle wins, so that cycle never expires.
  assign expire_pulse = tick && !load && (count == CW'(1));

  // Load from the bus, otherwise count down on each tick; zero means idle.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= '0;
      reload <= '0;
    end else if (load) begin
      count  <= ld_val;
      reload <= ld_val;
    end else if (tick) begin
      if (count == CW'(1)) begin
        count <= ar ? reload : '0;
      end else if (count != '0) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/floppy_timer_ctl.sv
// Four-channel tick-timer controller: shared prescaler, CTRL/STAT registers,
// sticky expiry flags and a registered level IRQ.
module floppy_timer_ctl
  import floppy_timer_pkg::*;
#(
  parameter int MCLKFREQ = MCLKFREQ_DEF,
  parameter int TICKHZ   = TICKHZ_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] addr,
  input  logic [7:0] di,
  input  logic       wren,
  output logic [7:0] dout,
  output logic       irq,
  output logic       tick
);

  localparam int             PDIV      = calc_div(MCLKFREQ, TICKHZ);
  localparam logic [PSW-1:0] PRESC_MAX = PSW'(PDIV - 1);

  logic [PSW-1:0] presc;
  ctrl_t          ctrl;
  logic [NCH-1:0] flags;
  logic [NCH-1:0] expire;
  logic [NCH-1:0] load;
  logic [NCH-1:0] clr;
  logic [CW-1:0]  count [NCH];
  logic           ctrl_wr;
  logic           stat_wr;

  // Tick is the single cycle in which the prescaler sits at zero.
  assign tick    = (presc == '0);
  assign ctrl_wr = wren && (addr == ADDR_CTRL);
  assign stat_wr = wren && (addr == ADDR_STAT);
  assign clr     = stat_wr ? di[NCH-1:0] : '0;

  // Free-running prescaler; register writes never touch it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= PRESC_MAX;
    end else if (presc == '0) begin
      presc <= PRESC_MAX;
    end else begin
      presc <= presc - PSW'(1);
    end
  end

  for (genvar n = 0; n < NCH; n++) begin : g_chan
    assign load[n] = wren && (addr == 3'(n));

    floppy_timer_chan u_chan (
      .clk          (clk),
      .reset        (reset),
      .tick         (tick),
      .load         (load[n]),
      .ld_val       (di),
      .ar           (ctrl.ar[n]),
      .count        (count[n]),
      .expire_pulse (expire[n])
    );
  end

  // CTRL register; channels see new auto-reload bits from the next tick on.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl <= '0;
    end else if (ctrl_wr) begin
      ctrl <= ctrl_t'(di);
    end
  end

  // Sticky flags: write-1-to-clear, with a same-cycle expiry taking priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags <= '0;
    end else begin
      flags <= (flags & ~clr) | expire;
    end
  end

  // Registered level interrupt from enabled flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq <= 1'b0;
    end else begin
      irq <= |(flags & ctrl.ie);
    end
  end

  // Zero-latency read mux over the current register state.
  // NOTE: dout gets a default before the case so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    dout = '0;
    case (addr)
      ADDR_CH0, ADDR_CH1, ADDR_CH2, ADDR_CH3: dout = count[addr[1:0]];
      ADDR_CTRL:                              dout = ctrl;
      ADDR_STAT:                              dout = {{(CW - NCH){1'b0}}, flags};
      default:                                dout = '0;
    endcase
  end

endmodule

// File: tb/tb_floppy_timer_ctl.sv
// Directed self-checking bench for floppy_timer_ctl at DIV = 10.
module tb_floppy_timer_ctl;
  import floppy_timer_pkg::*;

  localparam int TB_DIV = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] addr = '0;
  logic [7:0] di = '0;
  logic       wren = 1'b0;
  logic [7:0] dout;
  logic       irq;
  logic       tick;

  int checks = 0;
  int errors = 0;

  floppy_timer_ctl #(.MCLKFREQ(1000), .TICKHZ(100)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .di    (di),
    .wren  (wren),
    .dout  (dout),
    .irq   (irq),
    .tick  (tick)
  );

  always #5 clk = ~clk;

  // Returns at a falling edge inside a tick cycle (the next rising edge is the tick edge).
  task automatic wait_tick_cycle();
    int n = 0;
    @(negedge clk);
    while (tick !== 1'b1 && n < 3 * TB_DIV) begin
      @(negedge clk);
      n++;
    end
    if (tick !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout: no tick seen within %0d clocks", 3 * TB_DIV);
    end
  endtask

  // Returns 1 ns after the tick edge, so channel updates are visible.
  task automatic after_tick();
    wait_tick_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a;
    di   = d;
    wren = 1'b1;
    @(posedge clk);
    #1;
    wren = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] v);
    addr = a;
    #1;
    v = dout;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    logic       exp_tick;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
    checks++;
    if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b expected 0", tick); end
    reset = 1'b0;
    // Tick occupies the 10th and 20th clock periods after release (after edges 9 and 19).
    for (int k = 1; k <= 25; k++) begin
      @(posedge clk);
      #1;
      exp_tick = (k == TB_DIV - 1) || (k == 2 * TB_DIV - 1);
      checks++;
      if (tick !== exp_tick) begin
        errors++;
        $display("FAIL idle_tick k=%0d: got %b expected %b", k, tick, exp_tick);
      end
    end
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), v);
      checks++;
      if (v !== 8'h00) begin errors++; $display("FAIL idle_read addr=%0d: got %h expected 00", a, v); end
    end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL idle_irq: got %b expected 0", irq); end
  endtask

  task automatic test_one_shot();
    logic [7:0] v;
    after_tick();
    wr(ADDR_CH0, 8'd3);
    wr(ADDR_CTRL, 8'h10);
    rd(ADDR_CH0, v);
    checks++;
    if (v !== 8'd3) begin errors++; $display("FAIL ch0_loaded: got %0d expected 3", v); end
    after_tick();
    rd(ADDR_CH0, v);
    checks++;
    if (v !== 8'd2) begin errors++; $display("FAIL ch0_tick1: got %0d expected 2", v); end
    after_tick();
    rd(ADDR_CH0, v);
    checks++;
    if (v !== 8'd1) begin errors++; $display("FAIL ch0_tick2: got %0d expected 1", v); end
    after_tick();
    rd(ADDR_CH0, v);
    checks++;
    if (v !== 8'd0) begin errors++; $display("FAIL ch0_tick3: got %0d expected 0", v); end
    rd(ADDR_STAT, v);
    checks++;
    if (v !== 8'h01) begin errors++; $display("FAIL stat_after_expiry: got %h expected 01", v); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_latency: got %b expected 0", irq); end
    @(posedge clk);
    #1;
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_rise: got %b expected 1", irq); end
    wr(ADDR_STAT, 8'h01);
    rd(ADDR_STAT, v);
    checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL stat_w1c: got %h expected 00", v); end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_fall_latency: got %b expected 1", irq); end
    @(posedge clk);
    #1;
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_fall: got %b expected 0", irq); end
    after_tick();
    rd(ADDR_CH0, v);
    checks++;
    if (v !== 8'd0) begin errors++; $display("FAIL ch0_idle: got %0d expected 0", v); end
    rd(ADDR_STAT, v);
    checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL stat_idle: got %h expected 00", v); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_idle: got %b expected 0", irq); end
  endtask

  task automatic test_auto_reload();
    logic [7:0] v;
    logic [7:0] exp_cnt  [6] = '{8'd1, 8'd2, 8'd1, 8'd2, 8'd1, 8'd2};
    logic [7:0] exp_stat [6] = '{8'h00, 8'h02, 8'h00, 8'h02, 8'h00, 8'h02};
    after_tick();
    wr(ADDR_CH1, 8'd2);
    wr(ADDR_CTRL, 8'h22);
    for (int k = 0; k < 6; k++) begin
      after_tick();
      rd(ADDR_CH1, v);
      checks++;
      if (v !== exp_cnt[k]) begin
        errors++;
        $display("FAIL ch1_ar tick=%0d: got %0d expected %0d", k + 1, v, exp_cnt[k]);
      end
      rd(ADDR_STAT, v);
      checks++;
      if (v !== exp_stat[k]) begin
        errors++;
        $display("FAIL stat_ar tick=%0d: got %h expected %h", k + 1, v, exp_stat[k]);
      end
      if (exp_stat[k] != 8'h00) wr(ADDR_STAT, exp_stat[k]);
    end
    wr(ADDR_CTRL, 8'h00);
    wr(ADDR_CH1, 8'd0);
    wr(ADDR_STAT, 8'h0F);
  endtask

  task automatic test_collisions();
    logic [7:0] v;
    // CH2 write lands on the tick edge: the write wins, no decrement.
    wait_tick_cycle();
    addr = ADDR_CH2;
    di   = 8'd5;
    wren = 1'b1;
    @(posedge clk);
    #1;
    wren = 1'b0;
    rd(ADDR_CH2, v);
    checks++;
    if (v !== 8'd5) begin errors++; $display("FAIL ch2_write_on_tick: got %0d expected 5", v); end
    // STAT clear on the expiry edge: the set wins.
    wr(ADDR_CH2, 8'd1);
    wait_tick_cycle();
    addr = ADDR_STAT;
    di   = 8'h04;
    wren = 1'b1;
    @(posedge clk);
    #1;
    wren = 1'b0;
    rd(ADDR_STAT, v);
    checks++;
    if (v !== 8'h04) begin errors++; $display("FAIL set_beats_clear: got %h expected 04", v); end
    rd(ADDR_CH2, v);
    checks++;
    if (v !== 8'd0) begin errors++; $display("FAIL ch2_expired: got %0d expected 0", v); end
    wr(ADDR_STAT, 8'h04);
    rd(ADDR_STAT, v);
    checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL stat_clear2: got %h expected 00", v); end
    // Writing 0 stops a pending channel without a flag.
    wr(ADDR_CH2, 8'd1);
    wr(ADDR_CH2, 8'd0);
    after_tick();
    rd(ADDR_STAT, v);
    checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL stop_no_flag: got %h expected 00", v); end
    rd(ADDR_CH2, v);
    checks++;
    if (v !== 8'd0) begin errors++; $display("FAIL ch2_stopped: got %0d expected 0", v); end
  endtask

  task automatic test_all_channels();
    logic [7:0] v;
    logic [7:0] exp_stat [4] = '{8'h01, 8'h03, 8'h07, 8'h0F};
    after_tick();
    wr(ADDR_CH0, 8'd1);
    wr(ADDR_CH1, 8'd2);
    wr(ADDR_CH2, 8'd3);
    wr(ADDR_CH3, 8'd4);
    wr(ADDR_CTRL, 8'hF0);
    for (int k = 0; k < 4; k++) begin
      after_tick();
      rd(ADDR_STAT, v);
      checks++;
      if (v !== exp_stat[k]) begin
        errors++;
        $display("FAIL multi_stat tick=%0d: got %h expected %h", k + 1, v, exp_stat[k]);
      end
      @(posedge clk);
      #1;
      checks++;
      if (irq !== 1'b1) begin errors++; $display("FAIL multi_irq tick=%0d: got %b expected 1", k + 1, irq); end
    end
    rd(ADDR_CTRL, v);
    checks++;
    if (v !== 8'hF0) begin errors++; $display("FAIL ctrl_read: got %h expected f0", v); end
    wr(ADDR_STAT, 8'h0F);
    rd(ADDR_STAT, v);
    checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL multi_clear: got %h expected 00", v); end
    @(posedge clk);
    #1;
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL multi_irq_clear: got %b expected 0", irq); end
  endtask

  task automatic test_reset_mid_count();
    logic [7:0] v;
    logic       exp_tick;
    after_tick();
    wr(ADDR_CTRL, 8'h80);
    wr(ADDR_CH3, 8'd1);
    after_tick();
    @(posedge clk);
    #1;
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL pre_reset_irq: got %b expected 1", irq); end
    wr(ADDR_CH3, 8'd200);
    rd(ADDR_CH3, v);
    checks++;
    if (v !== 8'd200) begin errors++; $display("FAIL ch3_loaded: got %0d expected 200", v); end
    // Assert reset between clock edges; its effect must be immediate.
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL async_reset_irq: got %b expected 0", irq); end
    checks++;
    if (tick !== 1'b0) begin errors++; $display("FAIL async_reset_tick: got %b expected 0", tick); end
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), v);
      checks++;
      if (v !== 8'h00) begin errors++; $display("FAIL async_reset_read addr=%0d: got %h expected 00", a, v); end
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= TB_DIV; k++) begin
      @(posedge clk);
      #1;
      exp_tick = (k == TB_DIV - 1);
      checks++;
      if (tick !== exp_tick) begin
        errors++;
        $display("FAIL post_reset_tick k=%0d: got %b expected %b", k, tick, exp_tick);
      end
    end
    rd(ADDR_STAT, v);
    checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL post_reset_stat: got %h expected 00", v); end
    rd(ADDR_CH3, v);
    checks++;
    if (v !== 8'd0) begin errors++; $display("FAIL post_reset_ch3: got %0d expected 0", v); end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_collisions();
    test_all_channels();
    test_reset_mid_count();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
